// File: rtl/ram_bus_controller.sv
// ============================================================================
// Module      : ram_bus_controller
// Description : Valid/ready CPU request to asynchronous RAM bus-cycle master.
//               Optional write readback when RAMCTL_READBACK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_bus_controller #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int READ_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_write
);

    localparam int c_max_sr  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int c_max_cyc = (c_max_sr > READ_CYC) ? c_max_sr : READ_CYC;
    localparam int c_cnt_w   = (c_max_cyc > 1) ? $clog2(c_max_cyc) : 1;

    localparam logic [c_cnt_w-1:0] c_setup_ld  = c_cnt_w'(SETUP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_strobe_ld = c_cnt_w'(STROBE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_read_ld   = c_cnt_w'(READ_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_SETUP  = 3'd1,
        S_W_STROBE = 3'd2,
        S_W_HOLD   = 3'd3,
        S_R_WAIT   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_drive;
    logic                w_accept;
    logic                w_done;
    logic                w_sample;

`ifdef RAMCTL_READBACK_EN
    logic                r_write;
    logic                r_err;
    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

    // The bus is only ever driven from registered state, so the release is glitch-free.
    assign ram_data = r_drive ? r_wdata : {DATA_W{1'bz}};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_sample    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    w_accept = 1'b1;
                    if (req_write) begin
                        w_state_nxt = S_W_SETUP;
                        w_cnt_nxt   = c_setup_ld;
                    end else begin
                        w_state_nxt = S_R_WAIT;
                        w_cnt_nxt   = c_read_ld;
                    end
                end
            end
            S_W_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_W_STROBE;
                    w_cnt_nxt   = c_strobe_ld;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_W_STROBE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_W_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_W_HOLD: begin
`ifdef RAMCTL_READBACK_EN
                w_state_nxt = S_R_WAIT;
                w_cnt_nxt   = c_read_ld;
`else
                w_state_nxt = S_IDLE;
                w_done      = 1'b1;
`endif
            end
            S_R_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                    w_sample    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_wdata   <= '0;
            r_drive   <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ram_addr  <= '0;
            ram_write <= 1'b1;
`ifdef RAMCTL_READBACK_EN
            r_write   <= 1'b0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            req_ready <= (w_state_nxt == S_IDLE);
            ram_write <= (w_state_nxt != S_W_STROBE);
            r_drive   <= (w_state_nxt == S_W_SETUP) || (w_state_nxt == S_W_STROBE) ||
                         (w_state_nxt == S_W_HOLD);
            rsp_valid <= w_done;
            if (w_accept) begin
                r_wdata  <= req_wdata;
                ram_addr <= req_addr;
`ifdef RAMCTL_READBACK_EN
                r_write  <= req_write;
`endif
            end
            if (w_sample) begin
                rsp_rdata <= ram_data;
            end else if (w_done) begin
                rsp_rdata <= r_wdata;
            end
`ifdef RAMCTL_READBACK_EN
            if (w_sample) begin
                r_err <= r_write && (ram_data != r_wdata);
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_bus_controller.sv
// ============================================================================
// Module      : tb_ram_bus_controller
// Description : Randomized scoreboard bench for ram_bus_controller with an
//               asynchronous RAM bus model. Honours RAMCTL_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_bus_controller;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 8;
    localparam int SETUP_CYC  = 1;
    localparam int STROBE_CYC = 2;
    localparam int READ_CYC   = 2;

    typedef struct {
        int         due;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [7:0] req_addr  = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] ram_addr;
    logic       ram_write;
    wire  [7:0] ram_data;

    logic       bus_oe      = 1'b0;
    logic       stuck       = 1'b0;
    logic       armed       = 1'b0;
    logic       skip_strobe = 1'b0;
    logic [7:0] phys [256];
    logic [7:0] ref_mem [256];
    bit         oe_at [int];
    exp_t       sbq [$];
    logic [7:0] wq [$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;

    wire [7:0] bus_val = stuck ? 8'hAB : phys[ram_addr];
    assign ram_data = bus_oe ? bus_val : 8'bzzzzzzzz;

    ram_bus_controller #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .SETUP_CYC (SETUP_CYC),
        .STROBE_CYC(STROBE_CYC),
        .READ_CYC  (READ_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_write(ram_write)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Asynchronous RAM: writes while the strobe is low, drives reads only in the read windows.
    initial begin
        for (int i = 0; i < 256; i++) phys[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (!ram_write) phys[ram_addr] = ram_data;
            #1 bus_oe = oe_at.exists(cyc) ? 1'b1 : 1'b0;
        end
    end

    // Response scoreboard and bus-cycle monitor.
    initial begin
        exp_t       e;
        int         scnt;
        logic [7:0] prev_data;
        scnt      = 0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (armed) begin
                if (rsp_valid) begin
                    if (sbq.size() == 0) begin
                        flag("rsp_unexpected");
                    end else begin
                        e = sbq.pop_front();
                        chk("rsp_edge", cyc + 1, e.due);
                        chk("rsp_rdata", int'(rsp_rdata), int'(e.rdata));
                        chk("rsp_err", int'(rsp_err), int'(e.err));
                    end
                end else if (sbq.size() > 0 && cyc + 1 > sbq[0].due) begin
                    flag("rsp_timeout");
                    void'(sbq.pop_front());
                end
                if (!ram_write) begin
                    if (wq.size() == 0) begin
                        flag("strobe_unexpected");
                    end else begin
                        if (scnt == 0) chk("setup_data", int'(prev_data), int'(wq[0]));
                        chk("strobe_data", int'(ram_data), int'(wq[0]));
                    end
                    scnt++;
                end else if (scnt > 0) begin
                    if (!skip_strobe && wq.size() > 0) begin
                        chk("strobe_width", scnt, STROBE_CYC);
                        chk("hold_data", int'(ram_data), int'(wq[0]));
                    end
                    skip_strobe = 1'b0;
                    if (wq.size() > 0) void'(wq.pop_front());
                    scnt = 0;
                end
                if (req_ready && !bus_oe) chk("idle_bus_z", int'(ram_data === 8'bzzzzzzzz), 1);
            end
            prev_data = ram_data;
        end
    end

    // Presents one request (entered and left on a falling edge) and records what it must produce.
    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d, input bit drop);
        exp_t e;
        int   n;
        int   waitc;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        waitc     = 0;
        while (!req_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            flag("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        n = cyc + 1;
        if (w) begin
            wq.push_back(d);
            ref_mem[a] = d;
`ifdef RAMCTL_READBACK_EN
            e.due   = n + SETUP_CYC + STROBE_CYC + READ_CYC + 2;
            e.rdata = stuck ? 8'hAB : d;
            e.err   = stuck && (d != 8'hAB);
            if (!drop)
                for (int k = 0; k < READ_CYC; k++) oe_at[n + SETUP_CYC + STROBE_CYC + 1 + k] = 1'b1;
`else
            e.due   = n + SETUP_CYC + STROBE_CYC + 2;
            e.rdata = d;
            e.err   = 1'b0;
`endif
        end else begin
            e.due   = n + READ_CYC + 1;
            e.rdata = ref_mem[a];
            e.err   = 1'b0;
            for (int k = 0; k < READ_CYC; k++) oe_at[n + k] = 1'b1;
        end
        if (!drop) sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        req_valid = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int t = 0; t < 100 && sbq.size() > 0; t++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        // Reset held for three cycles, then released.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", int'(req_ready), 1);
        chk("reset_ram_write", int'(ram_write), 1);
        chk("reset_bus_z", int'(ram_data === 8'bzzzzzzzz), 1);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_rdata", int'(rsp_rdata), 0);
        chk("reset_rsp_err", int'(rsp_err), 0);
        chk("reset_ram_addr", int'(ram_addr), 0);
        armed = 1'b1;

        // Directed writes and reads.
        issue(1'b1, 8'h00, 8'hAA, 1'b0);
        drain();
        issue(1'b1, 8'h04, 8'hFE, 1'b0);
        idle(1);
        issue(1'b0, 8'h00, 8'h00, 1'b0);
        idle(2);
        issue(1'b0, 8'h04, 8'h00, 1'b0);
        drain();

        // Back-to-back with req_valid held high.
        issue(1'b1, 8'h08, 8'h5A, 1'b0);
        issue(1'b0, 8'h08, 8'h00, 1'b0);
        issue(1'b1, 8'h09, 8'hC3, 1'b0);
        issue(1'b0, 8'h00, 8'h00, 1'b0);
        drain();

        // Randomized traffic over a small address window so reads hit earlier writes.
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 8'h40 + 8'($urandom_range(0, 7));
            d = 8'($urandom);
            issue(w, a, d, 1'b0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        drain();

        // Reset during the strobe drops the write response and releases the bus at once.
        issue(1'b1, 8'h10, 8'h5C, 1'b1);
        @(negedge clk);
        skip_strobe = 1'b1;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        @(negedge clk);
        chk("rst_mid_ram_write", int'(ram_write), 1);
        chk("rst_mid_bus_z", int'(ram_data === 8'bzzzzzzzz), 1);
        chk("rst_mid_rsp_valid", int'(rsp_valid), 0);
        rst_n = 1'b1;
        idle(2);
        issue(1'b0, 8'h10, 8'h00, 1'b0);
        drain();

`ifdef RAMCTL_READBACK_EN
        // Stuck-bit bus on readback, then a clean RAM.
        stuck = 1'b1;
        issue(1'b1, 8'h20, 8'hAA, 1'b0);
        drain();
        stuck = 1'b0;
        issue(1'b1, 8'h21, 8'h3C, 1'b0);
        drain();
`endif

        if (sbq.size() != 0) flag("scoreboard_not_empty");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        flag("watchdog");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
